// File: rtl/axis_seq_checker.sv
// AXI-Stream incrementing-sequence checker: throttled registered tready, sync/track
// FSM, saturating beat/error counters, and a capture of the first mismatch.
`timescale 1ns/1ps
module axis_seq_checker #(
    parameter int unsigned AXIS_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic [3:0]            stall_period,
    input  logic                  clear,
    input  logic                  s_axis_tvalid,
    input  logic [AXIS_WIDTH-1:0] s_axis_tdata,
    output logic                  s_axis_tready,
    output logic [CNT_WIDTH-1:0]  beat_count,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic                  locked,
    output logic                  error,
    output logic [AXIS_WIDTH-1:0] err_expected,
    output logic [AXIS_WIDTH-1:0] err_received
);

    localparam logic [0:0] SYNC  = 1'b0;
    localparam logic [0:0] TRACK = 1'b1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [0:0]            state, state_nx;
    logic                  tready_q, tready_nx;
    logic [3:0]            stall_cnt, stall_cnt_nx;
    logic [3:0]            period_q, period_nx;
    logic [AXIS_WIDTH-1:0] expected_q, expected_nx;
    logic [CNT_WIDTH-1:0]  beat_q, beat_nx;
    logic [CNT_WIDTH-1:0]  err_q, err_nx;
    logic                  error_q, error_nx;
    logic [AXIS_WIDTH-1:0] cap_exp_q, cap_exp_nx;
    logic [AXIS_WIDTH-1:0] cap_rcv_q, cap_rcv_nx;
    logic                  hs_c;
    logic                  stall_hit_c;

    assign hs_c = s_axis_tvalid && tready_q;

    // Period is only re-sampled while ready is low (counter restart) or when unthrottled,
    // so a mid-run change never stretches a stall past one cycle.
    always_comb begin
        stall_hit_c  = tready_q && (period_q != 4'd0) && (stall_cnt >= 4'(period_q - 4'd1));
        tready_nx    = en && !stall_hit_c;
        stall_cnt_nx = (!tready_q || stall_hit_c) ? 4'd0 : 4'(stall_cnt + 4'd1);
        period_nx    = (!tready_q || (period_q == 4'd0)) ? stall_period : period_q;
    end

    // Next-state and checker datapath; clear wins over a coincident handshake.
    always_comb begin
        state_nx    = state;
        expected_nx = expected_q;
        beat_nx     = beat_q;
        err_nx      = err_q;
        error_nx    = error_q;
        cap_exp_nx  = cap_exp_q;
        cap_rcv_nx  = cap_rcv_q;
        if (clear) begin
            state_nx    = SYNC;
            expected_nx = '0;
            beat_nx     = '0;
            err_nx      = '0;
            error_nx    = 1'b0;
            cap_exp_nx  = '0;
            cap_rcv_nx  = '0;
        end else if (hs_c) begin
            expected_nx = AXIS_WIDTH'(s_axis_tdata + AXIS_WIDTH'(1));
            if (beat_q != CNT_MAX) begin
                beat_nx = CNT_WIDTH'(beat_q + CNT_WIDTH'(1));
            end
            if (state == SYNC) begin
                state_nx = TRACK;
            end else if (s_axis_tdata != expected_q) begin
                if (err_q != CNT_MAX) begin
                    err_nx = CNT_WIDTH'(err_q + CNT_WIDTH'(1));
                end
                if (!error_q) begin
                    error_nx   = 1'b1;
                    cap_exp_nx = expected_q;
                    cap_rcv_nx = s_axis_tdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= SYNC;
            tready_q   <= 1'b0;
            stall_cnt  <= 4'd0;
            period_q   <= 4'd0;
            expected_q <= '0;
            beat_q     <= '0;
            err_q      <= '0;
            error_q    <= 1'b0;
            cap_exp_q  <= '0;
            cap_rcv_q  <= '0;
        end else begin
            state      <= state_nx;
            tready_q   <= tready_nx;
            stall_cnt  <= stall_cnt_nx;
            period_q   <= period_nx;
            expected_q <= expected_nx;
            beat_q     <= beat_nx;
            err_q      <= err_nx;
            error_q    <= error_nx;
            cap_exp_q  <= cap_exp_nx;
            cap_rcv_q  <= cap_rcv_nx;
        end
    end

    assign s_axis_tready = tready_q;
    assign beat_count    = beat_q;
    assign err_count     = err_q;
    assign locked        = (state == TRACK);
    assign error         = error_q;
    assign err_expected  = cap_exp_q;
    assign err_received  = cap_rcv_q;

endmodule

// File: tb/tb_axis_seq_checker.sv
// Directed and randomized bench for axis_seq_checker against a rule-level model.
`timescale 1ns/1ps
module tb_axis_seq_checker;

    localparam int unsigned AW = 32;
    localparam int unsigned CW = 6;
    localparam int CMAX_I = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          en;
    logic [3:0]    stall_period;
    logic          clear;
    logic          tvalid;
    logic [AW-1:0] tdata;
    logic          s_axis_tready;
    logic [CW-1:0] beat_count;
    logic [CW-1:0] err_count;
    logic          locked;
    logic          error;
    logic [AW-1:0] err_expected;
    logic [AW-1:0] err_received;

    axis_seq_checker #(.AXIS_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (en),
        .stall_period (stall_period),
        .clear        (clear),
        .s_axis_tvalid(tvalid),
        .s_axis_tdata (tdata),
        .s_axis_tready(s_axis_tready),
        .beat_count   (beat_count),
        .err_count    (err_count),
        .locked       (locked),
        .error        (error),
        .err_expected (err_expected),
        .err_received (err_received)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit            m_ready;
    int            m_run;
    bit            m_locked;
    bit            m_error;
    logic [AW-1:0] m_exp;
    logic [AW-1:0] m_cap_e;
    logic [AW-1:0] m_cap_r;
    int            m_beats;
    int            m_errs;

    task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_error  = 1'b0;
        m_exp    = '0;
        m_cap_e  = '0;
        m_cap_r  = '0;
        m_beats  = 0;
        m_errs   = 0;
    endtask

    task automatic model_beat(input logic [AW-1:0] d);
        if (m_beats < CMAX_I) m_beats++;
        if (!m_locked) begin
            m_locked = 1'b1;
        end else if (d != m_exp) begin
            if (m_errs < CMAX_I) m_errs++;
            if (!m_error) begin
                m_error = 1'b1;
                m_cap_e = m_exp;
                m_cap_r = d;
            end
        end
        m_exp = d + AW'(1);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_beats"}, AW'(beat_count), AW'(m_beats));
        check({tag, "_errs"}, AW'(err_count), AW'(m_errs));
        check({tag, "_locked"}, AW'(locked), AW'(m_locked));
        check({tag, "_error"}, AW'(error), AW'(m_error));
        check({tag, "_cap_exp"}, err_expected, m_cap_e);
        check({tag, "_cap_rcv"}, err_received, m_cap_r);
    endtask

    // One clock: check ready, clock the DUT, advance the model, check status.
    task automatic step();
        bit hs;
        bit stall;
        check("tready", AW'(s_axis_tready), AW'(m_ready));
        hs = tvalid && m_ready;
        @(posedge clk);
        #1;
        if (clear) model_reset();
        else if (hs) model_beat(tdata);
        if (m_ready) m_run++;
        stall = (stall_period != 4'd0) && m_ready && (m_run >= int'(stall_period));
        if (!m_ready || stall) m_run = 0;
        m_ready = en && !stall;
        check_status("step");
    endtask

    task automatic send(input logic [AW-1:0] d);
        bit done = 1'b0;
        tvalid = 1'b1;
        tdata  = d;
        for (int i = 0; i < 20 && !done; i++) begin
            done = m_ready;
            step();
        end
        tvalid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $error("FAIL send_timeout observed=no_handshake expected=handshake data=%0h", d);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic set_period(input logic [3:0] p);
        en = 1'b0;
        stall_period = p;
        step();
        step();
        en = 1'b1;
        step();
    endtask

    initial begin
        reset_n = 1'b0;
        en = 1'b0;
        clear = 1'b0;
        tvalid = 1'b0;
        tdata = '0;
        stall_period = 4'd0;
        model_reset();
        m_ready = 1'b0;
        m_run = 0;

        #12;
        check("rst_tready", AW'(s_axis_tready), AW'(0));
        check("rst_beats", AW'(beat_count), AW'(0));
        check("rst_locked", AW'(locked), AW'(0));
        check("rst_error", AW'(error), AW'(0));
        reset_n = 1'b1;
        en = 1'b1;
        step();
        check("post_rst_tready", AW'(s_axis_tready), AW'(1));

        // Clean incrementing run
        for (int d = 16; d < 32; d++) send(AW'(d));
        check("r034_beats", AW'(beat_count), AW'(16));
        check("r034_errs", AW'(err_count), AW'(0));
        check("r034_error", AW'(error), AW'(0));
        check("r034_locked", AW'(locked), AW'(1));

        // One skipped value
        do_clear();
        send(AW'(5));
        send(AW'(6));
        send(AW'(8));
        send(AW'(9));
        check("r035_errs", AW'(err_count), AW'(1));
        check("r035_cap_exp", err_expected, AW'(7));
        check("r035_cap_rcv", err_received, AW'(8));

        // Wrap-around through all-ones
        do_clear();
        send(32'hFFFF_FFFE);
        send(32'hFFFF_FFFF);
        send(32'h0000_0000);
        send(32'h0000_0001);
        check("r036_errs", AW'(err_count), AW'(0));
        check("r036_beats", AW'(beat_count), AW'(4));
        check("r036_error", AW'(error), AW'(0));

        // Throttle pattern with period 3
        do_clear();
        set_period(4'd3);
        for (int k = 0; k < 20; k++) begin
            check("r037_pattern", AW'(s_axis_tready), AW'((k % 4) != 3));
            tvalid = 1'b1;
            tdata = AW'(m_beats);
            step();
        end
        tvalid = 1'b0;
        check("r037_beats", AW'(beat_count), AW'(15));
        check("r037_errs", AW'(err_count), AW'(0));
        set_period(4'd0);

        // Clear coincident with a bad beat
        do_clear();
        send(AW'(100));
        send(AW'(101));
        tvalid = 1'b1;
        tdata = AW'(555);
        clear = 1'b1;
        step();
        clear = 1'b0;
        tvalid = 1'b0;
        check("r038_beats", AW'(beat_count), AW'(0));
        check("r038_errs", AW'(err_count), AW'(0));
        check("r038_locked", AW'(locked), AW'(0));
        send(AW'(7));
        send(AW'(8));
        check("r038_resync_errs", AW'(err_count), AW'(0));
        check("r038_resync_beats", AW'(beat_count), AW'(2));

        // Asynchronous reset pulse between edges
        send(AW'(200));
        send(AW'(201));
        tvalid = 1'b1;
        tdata = AW'(202);
        #2;
        reset_n = 1'b0;
        #1;
        check("r039_tready", AW'(s_axis_tready), AW'(0));
        check("r039_beats", AW'(beat_count), AW'(0));
        check("r039_errs", AW'(err_count), AW'(0));
        check("r039_locked", AW'(locked), AW'(0));
        check("r039_error", AW'(error), AW'(0));
        check("r039_cap_exp", err_expected, AW'(0));
        #2;
        reset_n = 1'b1;
        model_reset();
        m_ready = 1'b0;
        m_run = 0;
        send(AW'(202));
        send(AW'(203));
        check("r039_resync_errs", AW'(err_count), AW'(0));
        check("r039_resync_beats", AW'(beat_count), AW'(2));
        check("r039_resync_locked", AW'(locked), AW'(1));

        // Counter saturation: every beat after the first is a mismatch
        do_clear();
        for (int i = 0; i < 70; i++) send(AW'(i * 2));
        check("sat_beats", AW'(beat_count), AW'(CMAX_I));
        check("sat_errs", AW'(err_count), AW'(CMAX_I));
        check("sat_cap_exp", err_expected, AW'(1));
        check("sat_cap_rcv", err_received, AW'(2));

        // Randomized traffic against the model
        for (int seg = 0; seg < 6; seg++) begin
            tvalid = 1'b0;
            do_clear();
            set_period(4'($urandom_range(0, 5)));
            for (int c = 0; c < 150; c++) begin
                tvalid = ($urandom_range(0, 3) != 0);
                tdata = ($urandom_range(0, 9) == 0 || !m_locked) ? AW'($urandom) : m_exp;
                clear = ($urandom_range(0, 99) == 0);
                step();
                clear = 1'b0;
            end
        end
        tvalid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_seq_checker.md
AXIS_SEQ_CHECKER -- requirements
Module: axis_seq_checker

Interface
REQ-001 The block SHALL have parameter AXIS_WIDTH, default 32, meaning the stream data width in bits.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, meaning the width of the beat and error counters.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit, which permits s_axis_tready to assert.
REQ-006 The block SHALL have port stall_period, input, 4 bits, the backpressure pattern; 0 means no throttling.
REQ-007 The block SHALL have port clear, input, 1 bit, a synchronous clear of all checker state.
REQ-008 The block SHALL have port s_axis_tvalid, input, 1 bit, upstream valid.
REQ-009 The block SHALL have port s_axis_tdata, input, AXIS_WIDTH bits, upstream data.
REQ-010 The block SHALL have port s_axis_tready, output, 1 bit, registered ready.
REQ-011 The block SHALL have port beat_count, output, CNT_WIDTH bits, the number of accepted beats.
REQ-012 The block SHALL have port err_count, output, CNT_WIDTH bits, the number of sequence mismatches.
REQ-013 The block SHALL have port locked, output, 1 bit, high once the first beat has been accepted.
REQ-014 The block SHALL have port error, output, 1 bit, a sticky flag set on the first mismatch.
REQ-015 The block SHALL have ports err_expected and err_received, outputs, AXIS_WIDTH bits each, holding the expected and received data captured at the first mismatch.

Function
REQ-016 A handshake SHALL occur in a cycle where s_axis_tvalid and s_axis_tready are both high; tdata is sampled only at a handshake.
REQ-017 s_axis_tready SHALL be a flop; when en=0 it SHALL be low on the next edge.
REQ-018 Throttle rule: with stall_period=N>0, a stall counter SHALL count ready-high cycles; after N consecutive ready-high cycles, tready SHALL be low for exactly 1 cycle, then the count restarts from 0.
REQ-019 Throttle rule: with stall_period=0 and en=1, tready SHALL stay continuously high; the stall counter SHALL count ready-high cycles whether or not tvalid is high.
REQ-020 The FSM SHALL have states SYNC and TRACK; reset and clear SHALL enter SYNC, and locked SHALL equal (state==TRACK).
REQ-021 In SYNC, a handshake SHALL load expected <= tdata+1 (modulo 2^AXIS_WIDTH) and move the FSM to TRACK; no comparison is made.
REQ-022 In TRACK, a handshake with tdata==expected SHALL set expected <= tdata+1.
REQ-023 In TRACK, a handshake with tdata!=expected SHALL increment err_count and resync expected <= tdata+1, so one skipped value yields one error.
REQ-024 On the first mismatch only (error was 0), err_expected and err_received SHALL capture the values and error SHALL set; later mismatches SHALL NOT overwrite them.
REQ-025 Wrap-around: when expected is all-ones, tdata all-ones SHALL be correct, and the next expected value SHALL be 0 with no error.
REQ-026 beat_count SHALL increment on every handshake in either state.
REQ-027 beat_count and err_count SHALL saturate at all-ones, not wrap.
REQ-028 Status outputs SHALL update on the clock edge that completes the handshake, i.e. they are visible the cycle after the handshake, with latency 1.
REQ-029 clear SHALL take priority over a simultaneous handshake: that beat is neither counted nor checked, and tready is unaffected by clear.
REQ-030 A change of stall_period mid-run SHALL take effect from the next stall-counter restart, and SHALL never produce a stall of 2 or more consecutive cycles.

Reset
REQ-031 Asserting reset_n low SHALL immediately, without waiting for clk, force s_axis_tready=0, state=SYNC, locked=0, error=0, counters=0, captures=0, and stall counter=0.
REQ-032 Deassertion of reset_n SHALL be synchronous to clk; tready SHALL rise no earlier than the first edge after release with en=1.
REQ-033 Reset mid-stream SHALL discard all state, and the next accepted beat SHALL be treated as a SYNC beat.

Verification
REQ-034 Incrementing source 0x10..0x1F, en=1, stall_period=0 -> beat_count=16, err_count=0, error=0, locked=1.
REQ-035 Sequence 5,6,8,9 -> err_count=1, err_expected=7, err_received=8, and no error on beat 9.
REQ-036 Sequence 0xFFFFFFFE,0xFFFFFFFF,0x0,0x1 -> err_count=0 and beat_count=4.
REQ-037 stall_period=3, tvalid held high for 20 cycles -> tready pattern is 1,1,1,0 repeating, and beat_count=15 after 20 cycles.
REQ-038 clear asserted in the same cycle as a handshake of a bad beat -> beat_count=0, err_count=0, locked=0, and the next beat re-syncs.
REQ-039 reset_n pulsed low between clock edges mid-stream -> tready and all status outputs are 0 before the next edge, and the next beat re-syncs without error.
